ps2_scan_fifo: RTL

- Parametrised successor to the keyboard-input path: receives PS/2 frames on the 25 MHz system clock instead of clocking logic from SCLK.
- Filters glitches on the PS/2 clock, checks parity and stop bits, and folds E0 (extended) and F0 (break) prefixes into per-key flags.
- Queues decoded key events in a show-ahead FIFO so VGAController can consume them with a RD handshake, and no strobe debouncer is needed.

---
 rtl/ps2_scan_fifo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver on the system clock: glitch filter, frame FSM, E0/F0 prefix folding, show-ahead event FIFO.
// Optional: define PS2_TYPEMATIC_FILTER_EN to drop repeated make codes while a key is held.
module ps2_scan_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                        CLK,
    input  logic                        ARST_L,
    input  logic                        SCLK,
    input  logic                        SDATA,
    input  logic                        RD,
    output logic                        VALID,
    output logic [7:0]                  KBCODE,
    output logic                        EXT,
    output logic                        KEYUP,
    output logic [$clog2(FIFO_DEPTH):0] COUNT,
    output logic                        OVF,
    output logic                        PERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    // Glitch filter: filt_cnt counts consecutive samples that disagree with filt_clk.
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (SCLK == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= SCLK;
                filt_cnt <= '0;
                fall     <= ~SCLK;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Frame FSM; state_q is the observable state for checkers.
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          frame_done;
    logic          frame_good;
    logic [7:0]    rx_byte;

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            IDLE:    if (fall && !SDATA) state_d = DATA;
            DATA:    if (fall && bit_cnt == 3'd7) state_d = PARITY;
            PARITY:  if (fall) state_d = STOP;
            STOP:    if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !fall && to_cnt == TO_LAST) begin
            state_d = IDLE;
            timeout = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt     <= '0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            rx_byte    <= '0;
        end else begin
            frame_done <= (state_q == STOP) && fall;
            frame_good <= (^{shift_q, par_q}) & SDATA;
            rx_byte    <= shift_q;
            if (state_q == IDLE || fall || timeout) to_cnt <= '0;
            else                                    to_cnt <= to_cnt + 1'b1;
            if (fall) begin
                case (state_q)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        shift_q <= {SDATA, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  par_q <= SDATA;
                    default: ;
                endcase
            end
        end
    end

    // Prefix folding: E0/F0 only arm flags; any other good byte becomes an event.
    logic       ext_pend, brk_pend, ext_d, brk_d;
    logic       is_e0, is_f0, key_evt, push_req;
    logic [8:0] ev_key;

    assign is_e0   = (rx_byte == 8'hE0);
    assign is_f0   = (rx_byte == 8'hF0);
    assign key_evt = frame_done & frame_good & ~is_e0 & ~is_f0;
    assign ev_key  = {ext_pend, rx_byte};

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic       repeat_make;
    assign repeat_make = ~brk_pend & (ev_key == last_make);

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L)                                   last_make <= 9'h000;
        else if (push_req && !brk_pend)                last_make <= ev_key;
        else if (key_evt && brk_pend && ev_key == last_make) last_make <= 9'h000;
    end
`else
    logic repeat_make;
    assign repeat_make = 1'b0;
`endif

    always_comb begin
        ext_d    = ext_pend;
        brk_d    = brk_pend;
        push_req = 1'b0;
        if (timeout) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (frame_done) begin
            if (!frame_good) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (is_e0) begin
                ext_d = 1'b1;
            end else if (is_f0) begin
                brk_d = 1'b1;
            end else begin
                push_req = ~repeat_make;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else begin
            ext_pend <= ext_d;
            brk_pend <= brk_d;
        end
    end

    // FIFO handshake: an entry is consumed on a CLK edge where RD=1 and VALID=1;
    // RD while VALID=0 has no effect. A push into a full FIFO succeeds only if a pop happens on the same edge.
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push, do_pop, full;
    logic [9:0]    head;

    assign full    = (count_q == FULL_CNT);
    assign do_pop  = RD & VALID;
    assign do_push = push_req & (~full | do_pop);

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= {ext_pend, brk_pend, rx_byte};
    end

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            OVF     <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            if (push_req && full && !do_pop) OVF <= 1'b1;
        end
    end

    assign head   = mem[rd_ptr];
    assign VALID  = (count_q != '0);
    assign KBCODE = VALID ? head[7:0] : 8'h00;
    assign EXT    = VALID & head[9];
    assign KEYUP  = VALID & head[8];
    assign COUNT  = count_q;
    assign PERR   = frame_done & ~frame_good;

endmodule
